// File: rtl/cache_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cache_cmd_sequencer
//  Description : Upstream feeder for the L1 cache. Accepts trace commands
//                (opcode + address) over a valid/ready handshake, drops
//                illegal opcodes, buffers legal ones in a circular FIFO and
//                issues them to the cache one at a time, waiting for the
//                cache's done pulse (or a watchdog expiry) between issues.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   clock, all state on the rising edge
//    rstb          in   asynchronous active-low reset
//    in_valid      in   trace command present
//    in_ready      out  room in the FIFO (count < DEPTH)
//    in_n          in   command opcode
//    in_addr       in   command address
//    cache_valid   out  one-cycle issue pulse to the cache
//    cache_n       out  opcode presented to the cache
//    cache_address out  address presented to the cache
//    cache_done    in   operation finished pulse from the cache
//    busy          out  FSM not idle or FIFO non-empty
//    count         out  FIFO occupancy
//    drop_cnt      out  illegal opcodes discarded (saturates at 255)
//    timeout_err   out  sticky watchdog expiry flag
// ============================================================================
module cache_cmd_sequencer #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_n,
    input  logic [ADDR_W-1:0]       in_addr,
    output logic                    cache_valid,
    output logic [3:0]              cache_n,
    output logic [ADDR_W-1:0]       cache_address,
    input  logic                    cache_done,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  count,
    output logic [7:0]              drop_cnt,
    output logic                    timeout_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_WD_W  = $clog2(TIMEOUT);

    localparam logic [c_PTR_W:0]   c_FULL     = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT - 1);
    localparam logic [3:0]         c_OP_CLEAR = 4'd8;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    logic [1:0]          r_state;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_count;
    logic [7:0]          r_drop_cnt;
    logic                r_timeout_err;
    logic [c_WD_W-1:0]   r_wd;
    logic [3:0]          r_cache_n;
    logic [ADDR_W-1:0]   r_cache_addr;

    logic [3:0]          r_mem_n    [DEPTH];
    logic [ADDR_W-1:0]   r_mem_addr [DEPTH];

    logic w_legal;
    logic w_accept;
    logic w_push;
    logic w_drop;
    logic w_pop;

    // Opcode 7 and 10..15 are not understood by the cache.
    assign w_legal  = (in_n <= 4'd6) || (in_n == 4'd8) || (in_n == 4'd9);
    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & w_legal;
    assign w_drop   = w_accept & ~w_legal;
    assign w_pop    = (r_state == c_ST_IDLE) && (r_count != '0);

    // in_ready looks only at the registered count, so a full FIFO refuses a
    // push even on an edge where it also pops.
    assign in_ready      = (r_count < c_FULL);
    assign cache_valid   = (r_state == c_ST_ISSUE);
    assign busy          = (r_state != c_ST_IDLE) || (r_count != '0);
    assign count         = r_count;
    assign drop_cnt      = r_drop_cnt;
    assign timeout_err   = r_timeout_err;
    assign cache_n       = r_cache_n;
    assign cache_address = r_cache_addr;

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_n[r_wr_ptr]    <= in_n;
            r_mem_addr[r_wr_ptr] <= in_addr;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_PTR_W + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (c_PTR_W + 1)'(1);
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state       <= c_ST_IDLE;
            r_cache_n     <= '0;
            r_cache_addr  <= '0;
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_cache_n    <= r_mem_n[r_rd_ptr];
                        r_cache_addr <= r_mem_addr[r_rd_ptr];
                        r_state      <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    // A clear resets the cache itself and never reports done.
                    if (r_cache_n == c_OP_CLEAR) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_wd    <= '0;
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (cache_done) begin
                        r_state <= c_ST_IDLE;
                    end else if (r_wd == c_WD_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= c_ST_IDLE;
                    end else begin
                        r_wd <= r_wd + c_WD_W'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_cmd_sequencer
//  Description : Directed self-checking bench for cache_cmd_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_cmd_sequencer;

    localparam int DEPTH      = 8;
    localparam int ADDR_W     = 32;
    localparam int TB_TIMEOUT = 64;

    logic                   clk;
    logic                   rstb;
    logic                   in_valid;
    logic                   in_ready;
    logic [3:0]             in_n;
    logic [ADDR_W-1:0]      in_addr;
    logic                   cache_valid;
    logic [3:0]             cache_n;
    logic [ADDR_W-1:0]      cache_address;
    logic                   cache_done;
    logic                   busy;
    logic [$clog2(DEPTH):0] count;
    logic [7:0]             drop_cnt;
    logic                   timeout_err;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0;

    logic [3:0]  fill_n  [9];
    logic [31:0] fill_a  [9];
    logic [3:0]  bad_ops [7];

    cache_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rstb          (rstb),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_n          (in_n),
        .in_addr       (in_addr),
        .cache_valid   (cache_valid),
        .cache_n       (cache_n),
        .cache_address (cache_address),
        .cache_done    (cache_done),
        .busy          (busy),
        .count         (count),
        .drop_cnt      (drop_cnt),
        .timeout_err   (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts issue pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (cache_valid) pulses <= pulses + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},    64'(in_ready),      64'd1);
        check({tag, "_cache_valid"}, 64'(cache_valid),   64'd0);
        check({tag, "_cache_n"},     64'(cache_n),       64'd0);
        check({tag, "_cache_addr"},  64'(cache_address), 64'd0);
        check({tag, "_busy"},        64'(busy),          64'd0);
        check({tag, "_count"},       64'(count),         64'd0);
        check({tag, "_drop_cnt"},    64'(drop_cnt),      64'd0);
        check({tag, "_timeout_err"}, 64'(timeout_err),   64'd0);
    endtask

    // Called in an ISSUE cycle: check the pulse, then answer with done.
    task automatic issue_and_done(input logic [3:0] en, input logic [31:0] ea);
        check("issue_valid", 64'(cache_valid),   64'd1);
        check("issue_n",     64'(cache_n),       64'(en));
        check("issue_addr",  64'(cache_address), 64'(ea));
        step();
        check("wait_no_valid", 64'(cache_valid), 64'd0);
        cache_done = 1'b1;
        step();
        cache_done = 1'b0;
    endtask

    initial begin
        fill_n  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd0};
        bad_ops = '{4'd7, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        for (int i = 0; i < 9; i++) fill_a[i] = 32'hA000_0000 + 32'(i) * 32'h111;

        rstb       = 1'b0;
        in_valid   = 1'b0;
        in_n       = 4'd0;
        in_addr    = '0;
        cache_done = 1'b0;
        #7;
        check_reset_outputs("reset");
        #5;
        rstb = 1'b1;
        step();

        // ---------------- single read ----------------
        in_valid = 1'b1; in_n = 4'd0; in_addr = 32'h1234_5678;
        step();                                   // edge 1: accept
        in_valid = 1'b0;
        check("rd_count_after_accept", 64'(count), 64'd1);
        check("rd_no_valid_yet", 64'(cache_valid), 64'd0);
        step();                                   // edge 2: pop -> ISSUE
        check("rd_valid", 64'(cache_valid), 64'd1);
        check("rd_n", 64'(cache_n), 64'd0);
        check("rd_addr", 64'(cache_address), 64'h1234_5678);
        check("rd_count_after_pop", 64'(count), 64'd0);
        step();                                   // edge 3: WAIT
        check("rd_valid_one_cycle", 64'(cache_valid), 64'd0);
        step();                                   // edge 4: still WAIT
        check("rd_busy_wait", 64'(busy), 64'd1);
        cache_done = 1'b1;
        step();                                   // edge 5: done
        cache_done = 1'b0;
        check("rd_busy_done", 64'(busy), 64'd0);
        check("rd_addr_held_idle", 64'(cache_address), 64'h1234_5678);

        // ---------------- fill / backpressure ----------------
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_n = fill_n[i]; in_addr = fill_a[i];
            step();
            if (i == 1) begin
                check("fill_first_valid", 64'(cache_valid), 64'd1);
                check("fill_first_addr", 64'(cache_address), 64'(fill_a[0]));
            end
        end
        check("fill_count_full", 64'(count), 64'd8);
        check("fill_in_ready_low", 64'(in_ready), 64'd0);
        in_n = 4'd3; in_addr = 32'hDEAD_BEEF;     // held while full
        step();
        check("fill_refused_count", 64'(count), 64'd8);
        cache_done = 1'b1;
        step();                                   // done -> IDLE
        cache_done = 1'b0;
        check("fill_idle_count", 64'(count), 64'd8);
        check("fill_idle_ready", 64'(in_ready), 64'd0);
        step();                                   // pop while full: push refused
        in_valid = 1'b0;
        check("fill_pop_full_count", 64'(count), 64'd7);
        for (int i = 1; i < 9; i++) begin
            issue_and_done(fill_n[i], fill_a[i]);
            if (i < 8) step();
        end
        check("fill_drained_count", 64'(count), 64'd0);
        check("fill_drained_busy", 64'(busy), 64'd0);

        // ---------------- illegal filter ----------------
        p0 = pulses;
        in_valid = 1'b1; in_n = 4'd7;  in_addr = 32'h0000_0700; step();
        in_n = 4'd1;  in_addr = 32'h0000_0100; step();
        in_n = 4'd10; in_addr = 32'h0000_0A00; step();
        check("ill_issue_n", 64'(cache_n), 64'd1);
        in_n = 4'd15; in_addr = 32'h0000_0F00; step();
        in_valid = 1'b0;
        check("ill_drop_cnt", 64'(drop_cnt), 64'd3);
        check("ill_count", 64'(count), 64'd0);
        check("ill_addr", 64'(cache_address), 64'h100);
        check("ill_pulses", 64'(pulses - p0), 64'd1);
        cache_done = 1'b1; step(); cache_done = 1'b0;

        p0 = pulses;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1; in_n = bad_ops[i % 7]; in_addr = 32'(i);
            step();
            if (i == 250) check("sat_drop_254", 64'(drop_cnt), 64'd254);
        end
        in_valid = 1'b0;
        check("sat_drop_255", 64'(drop_cnt), 64'd255);
        check("sat_count", 64'(count), 64'd0);
        check("sat_pulses", 64'(pulses - p0), 64'd0);

        // ---------------- clear command ----------------
        in_valid = 1'b1; in_n = 4'd8; in_addr = 32'h0000_0800; step();
        in_n = 4'd9; in_addr = 32'h0000_0900; step();
        in_valid = 1'b0;
        check("clr_valid", 64'(cache_valid), 64'd1);
        check("clr_n", 64'(cache_n), 64'd8);
        step();
        check("clr_gap_valid", 64'(cache_valid), 64'd0);
        check("clr_gap_count", 64'(count), 64'd1);
        step();
        check("clr_next_valid", 64'(cache_valid), 64'd1);
        check("clr_next_n", 64'(cache_n), 64'd9);
        check("clr_next_addr", 64'(cache_address), 64'h900);
        step();
        check("clr_timeout_err", 64'(timeout_err), 64'd0);
        cache_done = 1'b1; step(); cache_done = 1'b0;
        check("clr_busy", 64'(busy), 64'd0);

        // ---------------- watchdog ----------------
        in_valid = 1'b1; in_n = 4'd2; in_addr = 32'h0000_2222; step();
        in_valid = 1'b0;
        step();
        check("wd_issue", 64'(cache_valid), 64'd1);
        step();                                   // first WAIT cycle
        repeat (TB_TIMEOUT - 1) step();
        check("wd_still_waiting", 64'(busy), 64'd1);
        check("wd_no_err_yet", 64'(timeout_err), 64'd0);
        step();
        check("wd_err_set", 64'(timeout_err), 64'd1);
        check("wd_left_wait", 64'(busy), 64'd0);
        p0 = pulses;
        cache_done = 1'b1; step(); cache_done = 1'b0;   // stray done in IDLE
        repeat (3) step();
        check("wd_stray_busy", 64'(busy), 64'd0);
        check("wd_stray_pulses", 64'(pulses - p0), 64'd0);
        in_valid = 1'b1; in_n = 4'd3; in_addr = 32'h0000_3333; step();
        in_valid = 1'b0;
        step();
        issue_and_done(4'd3, 32'h0000_3333);
        check("wd_err_sticky", 64'(timeout_err), 64'd1);

        // ---------------- async reset mid-WAIT ----------------
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_n = 4'd1; in_addr = 32'h4000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        check("ar_queued", 64'(count), 64'd3);
        check("ar_busy", 64'(busy), 64'd1);
        #2;
        rstb = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        p0 = pulses;
        step();
        step();
        #3;
        rstb = 1'b1;
        repeat (10) step();
        check("ar_no_pulses", 64'(pulses - p0), 64'd0);
        check("ar_idle_busy", 64'(busy), 64'd0);
        check("ar_idle_count", 64'(count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_cmd_sequencer.md
# cache_cmd_sequencer

- Upstream feeder for the L1 cache top.
- Accepts trace commands (4-bit opcode n plus 32-bit address) from the trace reader through a valid/ready handshake.
- Queues them in a FIFO and issues them to the cache one at a time, as a one-cycle valid pulse with the opcode and address held stable.
- Waits for the cache's operation-finished indication before issuing the next command.
- Filters illegal opcodes and recovers from a hung operation with a watchdog.

## Interface
Parameters:
- DEPTH, 8 — FIFO entries; power of two, ≥2.
- ADDR_W, 32 — address width.
- TIMEOUT, 64 — maximum cycles to wait for cache_done; ≥4.

Ports:
- clk  in  1  — single clock; all state on rising edge.
- rstb  in  1  — one clock; reset is asynchronous and active-low.
- in_valid  in  1  — trace command present.
- in_ready  out  1  — sequencer can accept; equals (count < DEPTH).
- in_n  in  4  — command opcode.
- in_addr  in  ADDR_W  — command address.
- cache_valid  out  1  — one-cycle issue pulse to the cache.
- cache_n  out  4  — opcode presented to the cache.
- cache_address  out  ADDR_W  — address presented to the cache.
- cache_done  in  1  — operation finished; single-cycle pulse from the cache.
- busy  out  1  — state ≠ IDLE or FIFO non-empty.
- count  out  $clog2(DEPTH)+1  — FIFO occupancy.
- drop_cnt  out  8  — illegal opcodes discarded; saturates at 255.
- timeout_err  out  1  — sticky; set on watchdog expiry.

## Operation
- **Legal opcodes:** 0–6, 8, 9. Opcodes 7 and 10–15 are illegal.
  - An illegal opcode is handshaken normally (in_valid & in_ready) but not enqueued.
  - Each one increments drop_cnt, saturating at 255.
- **FIFO:** registered, circular, with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - Push when in_valid & in_ready & legal. Pop when state = IDLE & count ≠ 0.
  - Push and pop on the same edge leaves count unchanged.
  - in_ready depends only on count. At count = DEPTH, a push is refused even if a pop occurs on the same edge.
- **Issue FSM states:** IDLE, ISSUE, WAIT.
  - **IDLE:** if count ≠ 0, pop the head entry, load it into cache_n / cache_address, and go to ISSUE.
  - **ISSUE:** cache_valid = 1 for exactly this one cycle.
    - If cache_n = 8 (clear/reset), go to IDLE; the cache resets itself and produces no done.
    - Otherwise clear the watchdog counter and go to WAIT.
  - **WAIT:** cache_n and cache_address are held.
    - On cache_done, go to IDLE.
    - Otherwise the watchdog increments. When it reaches TIMEOUT−1 without done, set timeout_err and go to IDLE.
  - cache_done outside WAIT is ignored.
- cache_n and cache_address change only on the IDLE→ISSUE edge. They otherwise hold their last value, including in IDLE.
- timeout_err clears only on reset.
- Reset mid-operation (rstb low at any time) returns every output and state to the reset values asynchronously; queued commands are lost.

## Timing
- **Reset values:** in_ready = 1, cache_valid = 0, cache_n = 0, cache_address = 0, busy = 0, count = 0, drop_cnt = 0, timeout_err = 0. The FSM is in IDLE and the pointers are 0.
- **Issue latency:** a command accepted at edge k into an empty FIFO with the FSM in IDLE:
  - is popped at edge k+1;
  - drives cache_valid high in the cycle between edges k+1 and k+2.
- **Throughput:** a done sampled at edge d puts the FSM in IDLE after d. The next pop occurs at d+1 and the next cache_valid follows at d+1.
  - Minimum spacing of two cache_valid pulses is 3 cycles: ISSUE, WAIT with done, IDLE.
  - Back-to-back opcode-8 commands: cache_valid every 2 cycles.
- **Watchdog:** with no done, the FSM leaves WAIT after TIMEOUT cycles in WAIT; timeout_err is high from that edge.
- count updates on the accepting/popping edge. in_ready is combinational from registered count, so it has no combinational path from in_valid.

## Test plan
- **Single read:** reset, push n=0 addr=0x1234_5678 at edge 1 → cache_valid high during cycle 2 only, cache_n=0, cache_address=0x12345678; done at edge 5 → busy=0 by edge 6.
- **Fill/backpressure (DEPTH=8):** hold cache_done=0 and TIMEOUT large, push 9 legal commands → 8 accepted into FIFO plus 1 issued. in_ready=0 when count=8, with count=8 at the 9th accept. Then pulse done per issue → commands issued in push order with their addresses intact across pointer wrap.
- **Illegal filter:** push n=7, 10, 15 interleaved with n=1 → only n=1 reaches the cache, drop_cnt=3. Push 300 illegal opcodes → drop_cnt=255.
- **Clear command:** push n=8 then n=9 with no done → n=8 pulse, FSM returns to IDLE, n=9 pulse 2 cycles later; timeout_err stays 0.
- **Watchdog:** TIMEOUT=4, push n=2, never assert done → FSM leaves WAIT after 4 cycles, timeout_err=1 sticky. A stray cache_done in IDLE has no effect.
- **Async reset mid-WAIT:** 3 queued plus 1 in WAIT, drop rstb between edges → all outputs reach reset values immediately; after release, no cache_valid without new pushes.
